// File: rtl/cam_pkg.sv
// Shared types and helpers for the camera byte-pair capture front end.
package cam_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned PX_W   = 16;

  typedef enum logic [1:0] {
    MODE_RGB565 = 2'b00,
    MODE_RGB555 = 2'b01,
    MODE_RGB444 = 2'b10,
    MODE_YUV_Y  = 2'b11
  } cam_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FALL,
    ACTIVE,
    DONE
  } cam_state_e;

  // Bits needed to represent the values 0..n-1 (at least one bit).
  // Column/line counters need cam_bits(max+1); the address needs cam_bits(WIN_W*WIN_H).
  function automatic int unsigned cam_bits(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cam_capture_if.sv
// Sensor-side byte bus plus frame-buffer-side pixel write bus.
interface cam_capture_if #(
  parameter int unsigned ADDR_W = 17
);
  import cam_pkg::*;

  logic              vsync;
  logic              href;
  logic [BYTE_W-1:0] input_data;
  logic              px_valid;
  logic [PX_W-1:0]   px_data;
  logic [ADDR_W-1:0] px_addr;

  // Environment side: drives the sensor pins, receives pixel writes.
  modport master (
    output vsync, href, input_data,
    input  px_valid, px_data, px_addr
  );

  // Capture block side.
  modport slave (
    input  vsync, href, input_data,
    output px_valid, px_data, px_addr
  );

endinterface

// File: rtl/cam_px_pack.sv
// Combinational byte-pair to 16-bit pixel packer for the four pixel formats.
module cam_px_pack
  import cam_pkg::*;
(
  input  logic [BYTE_W-1:0] b0,
  input  logic [BYTE_W-1:0] b1,
  input  cam_mode_e         mode,
  output logic [PX_W-1:0]   pixel
);

  // Select the packing for the latched format; RGB555 drops the green LSB b1[5].
  always_comb begin
    pixel = '0;
    unique case (mode)
      MODE_RGB565: pixel = {b0, b1};
      MODE_RGB555: pixel = {1'b0, b0[7:3], b0[2:0], b1[7:6], b1[4:0]};
      MODE_RGB444: pixel = {4'h0, b0[3:0], b1};
      MODE_YUV_Y:  pixel = {8'h00, b0};
      default:     pixel = '0;
    endcase
  end

endmodule

// File: rtl/cam_capture.sv
// Camera capture front end: vsync/href framing FSM, byte-pair packing,
// window crop and linear frame-buffer addressing.
module cam_capture
  import cam_pkg::*;
#(
  parameter int unsigned SRC_W  = 320,
  parameter int unsigned SRC_H  = 240,
  parameter int unsigned WIN_W  = 320,
  parameter int unsigned WIN_H  = 240,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned X_W    = 10,
  parameter int unsigned Y_W    = 9
) (
  input  logic           pclk,
  input  logic           rst,
  input  logic           capture_en,
  cam_capture_if.slave   bus,
  input  logic [1:0]     mode,
  input  logic [X_W-1:0] win_x0,
  input  logic [Y_W-1:0] win_y0,
  output logic           frame_start,
  output logic           frame_done,
  output logic           line_err,
  output logic           frame_err,
  output logic [7:0]     frame_cnt,
  output logic           busy
);

  localparam logic [X_W:0]    SRC_W_C   = (X_W+1)'(SRC_W);
  localparam logic [X_W:0]    WIN_W_C   = (X_W+1)'(WIN_W);
  localparam logic [Y_W:0]    SRC_H_C   = (Y_W+1)'(SRC_H);
  localparam logic [Y_W:0]    WIN_H_C   = (Y_W+1)'(WIN_H);
  localparam logic [ADDR_W:0] PIX_TOTAL = (ADDR_W+1)'(WIN_W * WIN_H);

  cam_state_e state, state_nxt;

  logic              vsync_q, href_q;
  logic              vs_rise, vs_fall, href_fall;
  cam_mode_e         mode_q;
  logic [X_W-1:0]    x0_q;
  logic [Y_W-1:0]    y0_q;
  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic              phase;
  logic [BYTE_W-1:0] b0_q;
  logic [ADDR_W:0]   addr_cnt;
  logic [PX_W-1:0]   pixel;
  logic              px_valid_q;
  logic [PX_W-1:0]   px_data_q;
  logic [ADDR_W-1:0] px_addr_q;

  logic take_byte, take_even, take_odd, line_end, last_line;
  logic x_ok, y_ok, emit, relatch;

  cam_px_pack u_pack (
    .b0    (b0_q),
    .b1    (bus.input_data),
    .mode  (mode_q),
    .pixel (pixel)
  );

  assign vs_rise   = bus.vsync & ~vsync_q;
  assign vs_fall   = ~bus.vsync & vsync_q;
  assign href_fall = ~bus.href & href_q;

  // A vsync rise inside ACTIVE aborts the frame, so it suppresses capture that cycle.
  assign take_byte = (state == ACTIVE) && !vs_rise && bus.href;
  assign take_even = take_byte && !phase;
  assign take_odd  = take_byte && phase;
  assign line_end  = (state == ACTIVE) && !vs_rise && href_fall;
  assign last_line = (({1'b0, y} + 1'b1) == SRC_H_C);

  assign x_ok = ({1'b0, x} >= {1'b0, x0_q}) && ({1'b0, x} < ({1'b0, x0_q} + WIN_W_C));
  assign y_ok = ({1'b0, y} >= {1'b0, y0_q}) && ({1'b0, y} < ({1'b0, y0_q} + WIN_H_C));
  assign emit = take_odd && x_ok && y_ok && (addr_cnt < PIX_TOTAL);

  assign relatch = ((state == IDLE) && vs_rise && capture_en) ||
                   ((state == ACTIVE) && vs_rise);

  assign bus.px_valid = px_valid_q;
  assign bus.px_data  = px_data_q;
  assign bus.px_addr  = px_addr_q;

  // State register.
  always_ff @(posedge pclk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic for the framing FSM.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (vs_rise && capture_en) state_nxt = WAIT_FALL;
      WAIT_FALL: if (vs_fall) state_nxt = ACTIVE;
      ACTIVE: begin
        if (vs_rise)                    state_nxt = WAIT_FALL;
        else if (line_end && last_line) state_nxt = DONE;
      end
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy       = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      WAIT_FALL: busy = 1'b1;
      ACTIVE:    busy = 1'b1;
      DONE:      frame_done = 1'b1;
      default:   ;
    endcase
  end

  // Edge history, config latch, line/pixel counters and registered pixel output.
  always_ff @(posedge pclk) begin
    if (!rst) begin
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      mode_q      <= MODE_RGB565;
      x0_q        <= '0;
      y0_q        <= '0;
      x           <= '0;
      y           <= '0;
      phase       <= 1'b0;
      b0_q        <= '0;
      addr_cnt    <= '0;
      px_valid_q  <= 1'b0;
      px_data_q   <= '0;
      px_addr_q   <= '0;
      frame_start <= 1'b0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      vsync_q     <= bus.vsync;
      href_q      <= bus.href;
      px_valid_q  <= emit;
      frame_start <= take_even && (x == '0) && (y == '0);
      line_err    <= line_end && (({1'b0, x} != SRC_W_C) || phase);
      frame_err   <= (state == ACTIVE) && vs_rise;

      if (relatch) begin
        mode_q <= cam_mode_e'(mode);
        x0_q   <= win_x0;
        y0_q   <= win_y0;
      end

      if (state != ACTIVE) begin
        x        <= '0;
        y        <= '0;
        phase    <= 1'b0;
        addr_cnt <= '0;
      end else begin
        if (take_even) begin
          b0_q  <= bus.input_data;
          phase <= 1'b1;
        end
        // x saturates so an over-long line cannot wrap back into the window.
        if (take_odd) begin
          phase <= 1'b0;
          if (x != '1) x <= x + 1'b1;
        end
        if (emit) begin
          px_data_q <= pixel;
          px_addr_q <= addr_cnt[ADDR_W-1:0];
          addr_cnt  <= addr_cnt + 1'b1;
        end
        if (line_end) begin
          x     <= '0;
          phase <= 1'b0;
          y     <= y + 1'b1;
        end
      end

      if (state == DONE) frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_cam_capture.sv
// Scoreboard bench for cam_capture on a small 8x4 source with a 4x2 window.
module tb_cam_capture;
  import cam_pkg::*;

  localparam int unsigned SRC_W  = 8;
  localparam int unsigned SRC_H  = 4;
  localparam int unsigned WIN_W  = 4;
  localparam int unsigned WIN_H  = 2;
  localparam int unsigned X_W    = cam_bits(SRC_W + 1);
  localparam int unsigned Y_W    = cam_bits(SRC_H + 1);
  localparam int unsigned ADDR_W = cam_bits(WIN_W * WIN_H);

  localparam logic [15:0] SWEEP [4] = '{16'hABCD, 16'h55ED, 16'h0BCD, 16'h00AB};

  typedef struct {
    logic [15:0]       data;
    logic [ADDR_W-1:0] addr;
    int                cyc;
  } exp_t;

  logic           pclk = 1'b0;
  logic           rst;
  logic           capture_en;
  logic [1:0]     mode;
  logic [X_W-1:0] win_x0;
  logic [Y_W-1:0] win_y0;
  logic           frame_start, frame_done, line_err, frame_err, busy;
  logic [7:0]     frame_cnt;

  cam_capture_if #(.ADDR_W(ADDR_W)) bus ();

  cam_capture #(
    .SRC_W(SRC_W), .SRC_H(SRC_H), .WIN_W(WIN_W), .WIN_H(WIN_H),
    .ADDR_W(ADDR_W), .X_W(X_W), .Y_W(Y_W)
  ) dut (
    .pclk(pclk), .rst(rst), .capture_en(capture_en), .bus(bus),
    .mode(mode), .win_x0(win_x0), .win_y0(win_y0),
    .frame_start(frame_start), .frame_done(frame_done), .line_err(line_err),
    .frame_err(frame_err), .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 pclk = ~pclk;

  exp_t q[$];
  int   checks, errors;
  int   neg_n;
  int   n_px, n_fs, n_fd, n_le, n_fe;
  int   m_addr, m_x0, m_y0;
  logic [1:0] m_mode;
  bit   ab_mode;

  function automatic logic [15:0] ref_pack(logic [7:0] a, logic [7:0] b, logic [1:0] m);
    case (m)
      2'd0:    return {a, b};
      2'd1:    return {1'b0, a[7:3], a[2:0], b[7:6], b[4:0]};
      2'd2:    return {4'h0, a[3:0], b};
      default: return {8'h00, a};
    endcase
  endfunction

  // Called when the odd byte is driven; its capture edge is the next posedge,
  // so the strobe is due at the second negedge from now.
  function automatic void model_pixel(int x, int y, logic [7:0] a, logic [7:0] b);
    exp_t e;
    if (x >= m_x0 && x < m_x0 + int'(WIN_W) && y >= m_y0 && y < m_y0 + int'(WIN_H) &&
        m_addr < int'(WIN_W * WIN_H)) begin
      e.data = ab_mode ? SWEEP[m_mode] : ref_pack(a, b, m_mode);
      e.addr = ADDR_W'(m_addr);
      e.cyc  = neg_n + 2;
      q.push_back(e);
      m_addr++;
    end
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic clear_counts();
    n_px = 0; n_fs = 0; n_fd = 0; n_le = 0; n_fe = 0;
  endtask

  task automatic start_frame();
    m_addr = 0; m_mode = mode; m_x0 = int'(win_x0); m_y0 = int'(win_y0);
    bus.vsync = 1'b1;
    step(3);
    bus.vsync = 1'b0;
    step(3);
  endtask

  task automatic drive_line(input int y, input int nbytes);
    logic [7:0] a, b;
    a = '0;
    for (int i = 0; i < nbytes; i++) begin
      if (ab_mode) b = (i % 2 == 0) ? 8'hAB : 8'hCD;
      else         b = 8'($urandom);
      bus.href = 1'b1;
      bus.input_data = b;
      if (i % 2 == 0) a = b;
      else            model_pixel(i / 2, y, a, b);
      step(1);
    end
    bus.href = 1'b0;
    bus.input_data = '0;
    step(3);
  endtask

  task automatic run_frame(input int short_y, input int odd_y);
    int nb;
    start_frame();
    for (int y = 0; y < int'(SRC_H); y++) begin
      nb = 2 * int'(SRC_W);
      if (y == short_y) nb = 2 * (int'(SRC_W) - 1);
      if (y == odd_y)   nb = 2 * int'(SRC_W) - 1;
      drive_line(y, nb);
    end
    step(3);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(3);
    checks++; if ({bus.px_valid, bus.px_data, bus.px_addr, frame_start, frame_done, line_err, frame_err, frame_cnt, busy} !== '0) begin errors++; $display("FAIL reset_outputs: got valid=%b data=%h addr=%0d cnt=%0d busy=%b, want all 0", bus.px_valid, bus.px_data, bus.px_addr, frame_cnt, busy); end
    rst = 1'b1;
    step(3);
    checks++; if ({bus.px_valid, frame_start, frame_done, line_err, frame_err, frame_cnt, busy} !== '0) begin errors++; $display("FAIL reset_idle: got cnt=%0d busy=%b, want 0", frame_cnt, busy); end
  endtask

  task automatic test_full_frame();
    clear_counts();
    run_frame(-1, -1);
    checks++; if (n_px !== 8) begin errors++; $display("FAIL full_px_count: got %0d, want 8", n_px); end
    checks++; if (n_fs !== 1) begin errors++; $display("FAIL full_frame_start: got %0d pulses, want 1", n_fs); end
    checks++; if (n_fd !== 1) begin errors++; $display("FAIL full_frame_done: got %0d pulses, want 1", n_fd); end
    checks++; if (n_le !== 0 || n_fe !== 0) begin errors++; $display("FAIL full_errors: got line_err=%0d frame_err=%0d, want 0", n_le, n_fe); end
    checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL full_frame_cnt: got %0d, want 1", frame_cnt); end
    checks++; if (q.size() !== 0) begin errors++; $display("FAIL full_pending: got %0d missing strobes, want 0", q.size()); end
  endtask

  task automatic test_capture_en();
    logic [7:0] want;
    want = frame_cnt + 8'd1;
    clear_counts();
    start_frame();
    capture_en = 1'b0;
    for (int y = 0; y < int'(SRC_H); y++) drive_line(y, 2 * int'(SRC_W));
    step(3);
    checks++; if (n_fd !== 1 || n_px !== 8) begin errors++; $display("FAIL en_midframe: got done=%0d px=%0d, want 1 and 8", n_fd, n_px); end
    checks++; if (frame_cnt !== want) begin errors++; $display("FAIL en_frame_cnt: got %0d, want %0d", frame_cnt, want); end
    bus.vsync = 1'b1;
    step(3);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_disarmed_busy: got %b, want 0", busy); end
    bus.vsync = 1'b0;
    step(3);
    capture_en = 1'b1;
  endtask

  task automatic test_mode_sweep();
    ab_mode = 1'b1;
    for (int m = 0; m < 4; m++) begin
      clear_counts();
      mode = 2'(m);
      run_frame(-1, -1);
      checks++; if (n_px !== 8) begin errors++; $display("FAIL sweep_px_count mode %0d: got %0d, want 8", m, n_px); end
    end
    ab_mode = 1'b0;
    mode = 2'd0;
  endtask

  task automatic test_window_clip();
    win_x0 = X_W'(6);
    win_y0 = Y_W'(3);
    clear_counts();
    run_frame(-1, -1);
    checks++; if (n_px !== 2) begin errors++; $display("FAIL clip_px_count: got %0d, want 2", n_px); end
    checks++; if (n_fd !== 1 || n_le !== 0) begin errors++; $display("FAIL clip_flags: got done=%0d line_err=%0d, want 1 and 0", n_fd, n_le); end
    win_x0 = X_W'(2);
    win_y0 = Y_W'(1);
  endtask

  task automatic test_short_line();
    clear_counts();
    run_frame(2, -1);
    checks++; if (n_le !== 1) begin errors++; $display("FAIL short_line_err: got %0d pulses, want 1", n_le); end
    checks++; if (n_fd !== 1 || n_fe !== 0) begin errors++; $display("FAIL short_done: got done=%0d frame_err=%0d, want 1 and 0", n_fd, n_fe); end
    checks++; if (n_px !== 8) begin errors++; $display("FAIL short_px_count: got %0d, want 8", n_px); end
  endtask

  task automatic test_odd_byte();
    clear_counts();
    run_frame(-1, 0);
    checks++; if (n_le !== 1) begin errors++; $display("FAIL odd_line_err: got %0d pulses, want 1", n_le); end
    checks++; if (n_fd !== 1 || n_px !== 8) begin errors++; $display("FAIL odd_frame: got done=%0d px=%0d, want 1 and 8", n_fd, n_px); end
  endtask

  task automatic test_truncated();
    logic [7:0] want;
    want = frame_cnt + 8'd1;
    clear_counts();
    start_frame();
    for (int y = 0; y < 3; y++) drive_line(y, 2 * int'(SRC_W));
    start_frame();
    checks++; if (n_fe !== 1) begin errors++; $display("FAIL trunc_frame_err: got %0d pulses, want 1", n_fe); end
    checks++; if (n_fd !== 0 || n_px !== 8) begin errors++; $display("FAIL trunc_partial: got done=%0d px=%0d, want 0 and 8", n_fd, n_px); end
    for (int y = 0; y < int'(SRC_H); y++) drive_line(y, 2 * int'(SRC_W));
    step(3);
    checks++; if (n_fd !== 1 || n_px !== 16 || n_le !== 0) begin errors++; $display("FAIL trunc_recover: got done=%0d px=%0d line_err=%0d, want 1, 16, 0", n_fd, n_px, n_le); end
    checks++; if (frame_cnt !== want) begin errors++; $display("FAIL trunc_frame_cnt: got %0d, want %0d", frame_cnt, want); end
  endtask

  task automatic test_reset_midline();
    clear_counts();
    start_frame();
    bus.href = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.input_data = 8'($urandom);
      step(1);
    end
    rst = 1'b0;
    step(1);
    checks++; if ({bus.px_valid, bus.px_data, bus.px_addr, frame_start, frame_done, line_err, frame_err, frame_cnt, busy} !== '0) begin errors++; $display("FAIL midline_reset_outputs: got valid=%b data=%h addr=%0d cnt=%0d busy=%b, want all 0", bus.px_valid, bus.px_data, bus.px_addr, frame_cnt, busy); end
    bus.href = 1'b0;
    step(1);
    rst = 1'b1;
    step(4);
    checks++; if (n_fd !== 0 || n_le !== 0 || n_fe !== 0 || busy !== 1'b0) begin errors++; $display("FAIL midline_no_pulses: got done=%0d line_err=%0d frame_err=%0d busy=%b, want 0", n_fd, n_le, n_fe, busy); end
    checks++; if (q.size() !== 0) begin errors++; $display("FAIL midline_pending: got %0d queued, want 0", q.size()); end
  endtask

  task automatic test_frame_wrap();
    clear_counts();
    for (int f = 0; f < 255; f++) run_frame(-1, -1);
    checks++; if (frame_cnt !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d, want 255", frame_cnt); end
    run_frame(-1, -1);
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL wrap_0: got %0d, want 0", frame_cnt); end
    checks++; if (n_fd !== 256 || n_le !== 0 || n_fe !== 0) begin errors++; $display("FAIL wrap_flags: got done=%0d line_err=%0d frame_err=%0d, want 256, 0, 0", n_fd, n_le, n_fe); end
    checks++; if (q.size() !== 0) begin errors++; $display("FAIL wrap_pending: got %0d queued, want 0", q.size()); end
  endtask

  initial begin
    checks = 0; errors = 0; neg_n = 0;
    m_addr = 0; m_x0 = 0; m_y0 = 0; m_mode = 2'd0; ab_mode = 1'b0;
    clear_counts();
    rst = 1'b0; capture_en = 1'b1; mode = 2'd0;
    win_x0 = X_W'(2); win_y0 = Y_W'(1);
    bus.vsync = 1'b0; bus.href = 1'b0; bus.input_data = '0;

    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge pclk);
          neg_n++;
          if (bus.px_valid !== 1'b0) begin
            n_px++;
            checks++;
            if (q.size() == 0) begin
              errors++;
              $display("FAIL px_unexpected: got addr=%0d data=%h valid=%b, want no strobe", bus.px_addr, bus.px_data, bus.px_valid);
            end else begin
              e = q.pop_front();
              if (bus.px_data !== e.data || bus.px_addr !== e.addr || neg_n !== e.cyc) begin
                errors++;
                $display("FAIL px_out: got addr=%0d data=%h cyc=%0d, want addr=%0d data=%h cyc=%0d", bus.px_addr, bus.px_data, neg_n, e.addr, e.data, e.cyc);
              end
            end
          end
          if (frame_start === 1'b1) n_fs++;
          if (frame_done === 1'b1) n_fd++;
          if (line_err === 1'b1) n_le++;
          if (frame_err === 1'b1) n_fe++;
        end
      end
    join_none

    test_reset();
    test_full_frame();
    test_capture_en();
    test_mode_sweep();
    test_window_clip();
    test_short_line();
    test_odd_byte();
    test_truncated();
    test_reset_midline();
    test_frame_wrap();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
